// File: rtl/rocket_trace_fifo.sv
// Retire-trace FIFO: buffers a non-stallable commit stream, tags records with seq/core ID, drops and counts on full.
// Optional gap-marker records (one per run of drops) are enabled by defining ROCKET_TRACE_GAP_MARKER_EN.
module rocket_trace_fifo #(
    parameter int DEPTH   = 8,
    parameter int PC_W    = 40,
    parameter int INSN_W  = 32,
    parameter int CORE_ID = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       trace_valid,
    input  logic [PC_W-1:0]            trace_pc,
    input  logic [INSN_W-1:0]          trace_insn,
    input  logic                       trace_exception,
    input  logic [1:0]                 trace_priv,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [PC_W-1:0]            out_pc,
    output logic [INSN_W-1:0]          out_insn,
    output logic                       out_exception,
    output logic [1:0]                 out_priv,
    output logic [15:0]                out_seq,
    output logic [3:0]                 out_core_id,
    output logic                       out_gap,
    output logic [$clog2(DEPTH):0]     level,
    output logic [15:0]                drop_count,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef struct packed {
        logic              gap;
        logic [15:0]       seq;
        logic [1:0]        priv;
        logic              exc;
        logic [INSN_W-1:0] insn;
        logic [PC_W-1:0]   pc;
    } rec_t;

    rec_t          mem_q [DEPTH];
    rec_t          out_rec_q, out_rec_d;
    logic          out_valid_q, out_valid_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [15:0]   seq_q, seq_d;
    logic [15:0]   drop_count_q, drop_count_d;
    logic          overflow_q, overflow_d;

    logic pop, slot_free, push_en, drop;
    rec_t in_rec, wr_rec;

    assign pop       = out_valid_q && out_ready;
    assign slot_free = (level_q != FULL_LVL) || pop;

    always_comb begin
        in_rec      = '0;
        in_rec.pc   = trace_pc;
        in_rec.insn = trace_insn;
        in_rec.exc  = trace_exception;
        in_rec.priv = trace_priv;
        in_rec.seq  = seq_q;
    end

`ifdef ROCKET_TRACE_GAP_MARKER_EN
    typedef enum logic {NORMAL = 1'b0, GAP_PENDING = 1'b1} gap_state_e;

    gap_state_e  state_q, state_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] gap_seq_q, gap_seq_d;
    logic        marker_en;
    rec_t        marker_rec;

    // The marker takes the free slot; a record arriving alongside it starts a new gap.
    assign marker_en = (state_q == GAP_PENDING) && slot_free;
    assign push_en   = marker_en || (trace_valid && slot_free);
    assign drop      = trace_valid && (!slot_free || marker_en);

    always_comb begin
        marker_rec     = '0;
        marker_rec.gap = 1'b1;
        marker_rec.pc  = PC_W'(gap_cnt_q);
        marker_rec.seq = gap_seq_q;
        wr_rec         = marker_en ? marker_rec : in_rec;
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        gap_seq_d = gap_seq_q;
        case (state_q)
            NORMAL: begin
                if (drop) begin
                    state_d   = GAP_PENDING;
                    gap_cnt_d = 16'd1;
                    gap_seq_d = seq_q;
                end
            end
            GAP_PENDING: begin
                if (marker_en) begin
                    if (trace_valid) begin
                        gap_cnt_d = 16'd1;
                        gap_seq_d = seq_q;
                    end else begin
                        state_d = NORMAL;
                    end
                end else if (drop && gap_cnt_q != 16'hFFFF) begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: state_d = NORMAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= NORMAL;
            gap_cnt_q <= '0;
            gap_seq_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
            gap_seq_q <= gap_seq_d;
        end
    end
`else
    assign push_en = trace_valid && slot_free;
    assign drop    = trace_valid && !slot_free;
    assign wr_rec  = in_rec;
`endif

    always_comb begin
        wr_ptr_d     = wr_ptr_q + AW'(push_en);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        seq_d        = seq_q + 16'(trace_valid);
        overflow_d   = overflow_q | drop;
        drop_count_d = drop_count_q;
        if (drop && drop_count_q != 16'hFFFF)
            drop_count_d = drop_count_q + 16'd1;
        level_d = level_q;
        case ({push_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
        // Next head comes from the incoming write when it lands on the new read slot.
        out_valid_d = (level_d != '0);
        out_rec_d   = '0;
        if (out_valid_d) begin
            if (push_en && wr_ptr_q == rd_ptr_d)
                out_rec_d = wr_rec;
            else
                out_rec_d = mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && push_en)
            mem_q[wr_ptr_q] <= wr_rec;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_rec_q    <= '0;
            out_valid_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            seq_q        <= '0;
            drop_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            out_rec_q    <= out_rec_d;
            out_valid_q  <= out_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            seq_q        <= seq_d;
            drop_count_q <= drop_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = out_rec_q.pc;
    assign out_insn      = out_rec_q.insn;
    assign out_exception = out_rec_q.exc;
    assign out_priv      = out_rec_q.priv;
    assign out_seq       = out_rec_q.seq;
    assign out_gap       = out_rec_q.gap;
    assign out_core_id   = 4'(CORE_ID);
    assign level         = level_q;
    assign drop_count    = drop_count_q;
    assign overflow      = overflow_q;
endmodule

// File: tb/tb_rocket_trace_fifo.sv
// Directed self-checking bench for rocket_trace_fifo (DEPTH=8, PC_W=40, INSN_W=32, CORE_ID=0).
module tb_rocket_trace_fifo;
    logic        clock = 1'b0;
    logic        reset;
    logic        trace_valid;
    logic [39:0] trace_pc;
    logic [31:0] trace_insn;
    logic        trace_exception;
    logic [1:0]  trace_priv;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_pc;
    logic [31:0] out_insn;
    logic        out_exception;
    logic [1:0]  out_priv;
    logic [15:0] out_seq;
    logic [3:0]  out_core_id;
    logic        out_gap;
    logic [3:0]  level;
    logic [15:0] drop_count;
    logic        overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    rocket_trace_fifo #(.DEPTH(8), .PC_W(40), .INSN_W(32), .CORE_ID(0)) dut (
        .clock(clock), .reset(reset),
        .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_insn(trace_insn),
        .trace_exception(trace_exception), .trace_priv(trace_priv),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_insn(out_insn), .out_exception(out_exception),
        .out_priv(out_priv), .out_seq(out_seq), .out_core_id(out_core_id),
        .out_gap(out_gap), .level(level), .drop_count(drop_count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    // Advance one edge; inputs change and outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        trace_valid = 1'b0;
        out_ready   = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        trace_pc = 40'h12345; trace_insn = 32'h13; trace_exception = 1'b1; trace_priv = 2'd3;
        do_reset();
        tests_run++;
        if (out_valid !== 1'b0 || level !== 4'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got valid=%b level=%0d drop=%0d ovf=%b, expected 0 0 0 0",
                     out_valid, level, drop_count, overflow);
        end
        tests_run++;
        if (out_gap !== 1'b0 || out_pc !== 40'd0 || out_seq !== 16'd0 || out_insn !== 32'd0 || out_core_id !== 4'd0) begin
            tests_failed++;
            $display("FAIL reset_data: got gap=%b pc=%h seq=%h insn=%h core=%h, expected all 0",
                     out_gap, out_pc, out_seq, out_insn, out_core_id);
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_single();
        do_reset();
        trace_valid = 1'b1; trace_pc = 40'h80000000; trace_insn = 32'h00000013;
        trace_exception = 1'b1; trace_priv = 2'd3; out_ready = 1'b1;
        tick();
        trace_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_pc !== 40'h80000000 || out_insn !== 32'h13 || out_seq !== 16'd0 || level !== 4'd1) begin
            tests_failed++;
            $display("FAIL single_head: got valid=%b pc=%h insn=%h seq=%h level=%0d, expected 1 80000000 13 0 1",
                     out_valid, out_pc, out_insn, out_seq, level);
        end
        tests_run++;
        if (out_exception !== 1'b1 || out_priv !== 2'd3 || out_gap !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_fields: got exc=%b priv=%0d gap=%b, expected 1 3 0", out_exception, out_priv, out_gap);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            tests_failed++;
            $display("FAIL single_drain: got valid=%b level=%0d, expected 0 0", out_valid, level);
        end
        $display("[TB] test_single done");
    endtask

    task automatic test_overflow();
        do_reset();
        trace_exception = 1'b0; trace_priv = 2'd0; trace_insn = 32'hA5A5_0000;
        for (int i = 0; i < 10; i++) begin
            trace_valid = 1'b1; trace_pc = 40'h1000 + 40'(i);
            tick();
        end
        trace_valid = 1'b0;
        tests_run++;
        if (level !== 4'd8 || drop_count !== 16'd2 || overflow !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow_state: got level=%0d drop=%0d ovf=%b, expected 8 2 1", level, drop_count, overflow);
        end
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                out_ready = 1'b0;
                tick();
                tick();
                tests_run++;
                if (out_valid !== 1'b1 || out_seq !== 16'd3 || out_pc !== 40'h1003) begin
                    tests_failed++;
                    $display("FAIL overflow_stall: got valid=%b seq=%h pc=%h, expected 1 0003 1003", out_valid, out_seq, out_pc);
                end
            end
            tests_run++;
            if (out_valid !== 1'b1 || out_seq !== 16'(i) || out_pc !== 40'h1000 + 40'(i)) begin
                tests_failed++;
                $display("FAIL overflow_drain[%0d]: got valid=%b seq=%h pc=%h, expected 1 %h %h",
                         i, out_valid, out_seq, out_pc, 16'(i), 40'h1000 + 40'(i));
            end
            out_ready = 1'b1;
            tick();
        end
        out_ready = 1'b0;
`ifndef ROCKET_TRACE_GAP_MARKER_EN
        tests_run++;
        if (out_valid !== 1'b0 || level !== 4'd0 || overflow !== 1'b1 || drop_count !== 16'd2) begin
            tests_failed++;
            $display("FAIL overflow_end: got valid=%b level=%0d ovf=%b drop=%0d, expected 0 0 1 2",
                     out_valid, level, overflow, drop_count);
        end
`endif
        $display("[TB] test_overflow done");
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            trace_valid = 1'b1; trace_pc = 40'h2000 + 40'(i);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            tests_run++;
            if (out_seq !== 16'(k) || level !== 4'd8) begin
                tests_failed++;
                $display("FAIL fullpp_step[%0d]: got seq=%h level=%0d, expected %h 8", k, out_seq, level, 16'(k));
            end
            trace_valid = 1'b1; trace_pc = 40'h2000 + 40'(8 + k); out_ready = 1'b1;
            tick();
        end
        trace_valid = 1'b0; out_ready = 1'b0;
        tests_run++;
        if (level !== 4'd8 || drop_count !== 16'd0 || overflow !== 1'b0 || out_seq !== 16'd5) begin
            tests_failed++;
            $display("FAIL fullpp_state: got level=%0d drop=%0d ovf=%b seq=%h, expected 8 0 0 0005",
                     level, drop_count, overflow, out_seq);
        end
        out_ready = 1'b1;
        for (int i = 5; i < 13; i++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_seq !== 16'(i) || out_pc !== 40'h2000 + 40'(i)) begin
                tests_failed++;
                $display("FAIL fullpp_drain[%0d]: got valid=%b seq=%h pc=%h", i, out_valid, out_seq, out_pc);
            end
            tick();
        end
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            tests_failed++;
            $display("FAIL fullpp_end: got valid=%b level=%0d, expected 0 0", out_valid, level);
        end
        $display("[TB] test_full_push_pop done");
    endtask

    task automatic test_seq_wrap();
        do_reset();
        out_ready = 1'b1;
        for (int n = 0; n < 32'h10005; n++) begin
            trace_valid = 1'b1; trace_pc = 40'(n);
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_seq !== 16'(n) || level !== 4'd1) begin
                tests_failed++;
                $display("FAIL wrap[%0d]: got valid=%b seq=%h level=%0d, expected 1 %h 1", n, out_valid, out_seq, level, 16'(n));
            end
        end
        trace_valid = 1'b0;
        tests_run++;
        if (out_seq !== 16'h0004 || out_pc !== 40'h10004 || drop_count !== 16'd0) begin
            tests_failed++;
            $display("FAIL wrap_last: got seq=%h pc=%h drop=%0d, expected 0004 10004 0", out_seq, out_pc, drop_count);
        end
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || level !== 4'd0) begin
            tests_failed++;
            $display("FAIL wrap_end: got valid=%b level=%0d, expected 0 0", out_valid, level);
        end
        $display("[TB] test_seq_wrap done");
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            trace_valid = 1'b1; trace_pc = 40'h4000 + 40'(i);
            tick();
        end
        tests_run++;
        if (level !== 4'd5) begin
            tests_failed++;
            $display("FAIL midrst_pre: got level=%0d, expected 5", level);
        end
        trace_valid = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; trace_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || level !== 4'd0 || drop_count !== 16'd0 || overflow !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_flush: got valid=%b level=%0d drop=%0d ovf=%b, expected 0 0 0 0",
                     out_valid, level, drop_count, overflow);
        end
        trace_valid = 1'b1; trace_pc = 40'h3000;
        tick();
        trace_valid = 1'b0;
        tests_run++;
        if (out_valid !== 1'b1 || out_seq !== 16'd0 || out_pc !== 40'h3000 || level !== 4'd1) begin
            tests_failed++;
            $display("FAIL midrst_next: got valid=%b seq=%h pc=%h level=%0d, expected 1 0000 3000 1",
                     out_valid, out_seq, out_pc, level);
        end
        $display("[TB] test_mid_reset done");
    endtask

`ifdef ROCKET_TRACE_GAP_MARKER_EN
    task automatic test_gap_marker();
        do_reset();
        trace_insn = 32'h0000_0013; trace_exception = 1'b1; trace_priv = 2'd1;
        for (int i = 0; i < 11; i++) begin
            trace_valid = 1'b1; trace_pc = 40'h5000 + 40'(i);
            tick();
        end
        trace_valid = 1'b0;
        tests_run++;
        if (level !== 4'd8 || drop_count !== 16'd3 || out_gap !== 1'b0) begin
            tests_failed++;
            $display("FAIL gap_fill: got level=%0d drop=%0d gap=%b, expected 8 3 0", level, drop_count, out_gap);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (level !== 4'd8 || out_seq !== 16'd1) begin
            tests_failed++;
            $display("FAIL gap_pop1: got level=%0d seq=%h, expected 8 0001", level, out_seq);
        end
        out_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tests_run++;
            if (out_gap !== 1'b0 || out_seq !== 16'(i)) begin
                tests_failed++;
                $display("FAIL gap_drain[%0d]: got gap=%b seq=%h", i, out_gap, out_seq);
            end
            tick();
        end
        tests_run++;
        if (out_valid !== 1'b1 || out_gap !== 1'b1 || out_pc !== 40'd3 || out_seq !== 16'd8 ||
            out_insn !== 32'd0 || out_exception !== 1'b0 || out_priv !== 2'd0) begin
            tests_failed++;
            $display("FAIL gap_marker: got valid=%b gap=%b pc=%h seq=%h insn=%h exc=%b priv=%0d, expected 1 1 3 0008 0 0 0",
                     out_valid, out_gap, out_pc, out_seq, out_insn, out_exception, out_priv);
        end
        tick();
        out_ready = 1'b0;
        tests_run++;
        if (out_valid !== 1'b0 || drop_count !== 16'd3) begin
            tests_failed++;
            $display("FAIL gap_end: got valid=%b drop=%0d, expected 0 3", out_valid, drop_count);
        end
        $display("[TB] test_gap_marker done");
    endtask
`endif

    initial begin
        reset = 1'b1; trace_valid = 1'b0; out_ready = 1'b0;
        trace_pc = '0; trace_insn = '0; trace_exception = 1'b0; trace_priv = '0;
        test_reset();
        test_single();
        test_overflow();
        test_full_push_pop();
        test_seq_wrap();
        test_mid_reset();
`ifdef ROCKET_TRACE_GAP_MARKER_EN
        test_gap_marker();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
